// File: rtl/rpn_evaluator.sv
// rpn_evaluator
//   Evaluates a postfix (RPN) token stream on an internal operand stack and
//   presents the final value downstream when the '=' token arrives. It sits
//   directly behind the infix-to-postfix converter and uses the same stb/ack
//   token handshake on its input.
//
// Ports
//   CLK                clock, all logic on the rising edge
//   RST                synchronous active-high reset
//   input_stb          token valid, held by the sender until input_ack
//   input_data         operand value, or opcode in bits [2:0]
//   is_input_operator  1: input_data[2:0] is an opcode, 0: operand
//   input_ack          one-cycle pulse, token consumed
//   output_stb         result valid, held until output_ack
//   output_data        expression result
//   output_error       result invalid (stack or opcode fault), valid with output_stb
//   output_ack         downstream has taken the result
//
// Opcodes: 001 '*', 010 '+', 011 '-', 100 '='. Anything else is illegal.
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             input_stb,
  input  logic [WIDTH-1:0] input_data,
  input  logic             is_input_operator,
  output logic             input_ack,
  output logic             output_stb,
  output logic [WIDTH-1:0] output_data,
  output logic             output_error,
  input  logic             output_ack
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] SP_ONE  = PW'(1);
  localparam logic [PW-1:0] SP_TWO  = PW'(2);

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ACK,
    RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic [2:0]       op_q, op_d;
  logic             input_ack_q, input_ack_d;
  logic             output_stb_q, output_stb_d;
  logic [WIDTH-1:0] output_data_q, output_data_d;
  logic             output_error_q, output_error_d;

  // The operand stack is not reset: sp alone defines which entries are live.
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             stack_we;
  logic [PW-1:0]    stack_waddr;
  logic [WIDTH-1:0] stack_wdata;

  logic [PW-1:0]    sp_m1, sp_m2;
  logic [WIDTH-1:0] opnd_a, opnd_b, alu_result;

  assign sp_m1  = sp_q - SP_ONE;
  assign sp_m2  = sp_q - SP_TWO;
  // a is the deeper entry, b the top: '-' computes a - b.
  assign opnd_a = stack_q[sp_m2];
  assign opnd_b = stack_q[sp_m1];

  always_comb begin
    alu_result = opnd_a;
    case (op_q)
      OP_MUL:  alu_result = opnd_a * opnd_b;
      OP_ADD:  alu_result = opnd_a + opnd_b;
      OP_SUB:  alu_result = opnd_a - opnd_b;
      default: alu_result = opnd_a;
    endcase
  end

  // Next-state logic. input_ack defaults low so it can only ever pulse for a
  // single cycle, and every accepted token passes through ACK so the sender
  // has dropped its stb before IDLE samples again.
  always_comb begin
    state_d        = state_q;
    sp_d           = sp_q;
    err_d          = err_q;
    op_d           = op_q;
    input_ack_d    = 1'b0;
    output_stb_d   = output_stb_q;
    output_data_d  = output_data_q;
    output_error_d = output_error_q;
    stack_we       = 1'b0;
    stack_waddr    = sp_q;
    stack_wdata    = input_data;

    case (state_q)
      IDLE: begin
        if (input_stb) begin
          if (!is_input_operator) begin
            if (sp_q < SP_FULL) begin
              stack_we    = 1'b1;
              stack_waddr = sp_q;
              stack_wdata = input_data;
              sp_d        = sp_q + SP_ONE;
            end else begin
              err_d = 1'b1;
            end
            input_ack_d = 1'b1;
            state_d     = ACK;
          end else begin
            case (input_data[2:0])
              OP_MUL, OP_ADD, OP_SUB: begin
                op_d    = input_data[2:0];
                state_d = EXEC;
              end
              OP_EQ: begin
                output_stb_d   = 1'b1;
                output_error_d = err_q | (sp_q != SP_ONE);
                output_data_d  = (sp_q >= SP_ONE) ? opnd_b : '0;
                state_d        = RESULT;
              end
              default: begin
                err_d       = 1'b1;
                input_ack_d = 1'b1;
                state_d     = ACK;
              end
            endcase
          end
        end
      end

      EXEC: begin
        if (sp_q >= SP_TWO) begin
          stack_we    = 1'b1;
          stack_waddr = sp_m2;
          stack_wdata = alu_result;
          sp_d        = sp_m1;
        end else begin
          err_d = 1'b1;
        end
        input_ack_d = 1'b1;
        state_d     = ACK;
      end

      // The '=' token is only acknowledged once the result has been taken,
      // which also clears the stack for the next expression.
      RESULT: begin
        if (output_ack) begin
          output_stb_d = 1'b0;
          input_ack_d  = 1'b1;
          sp_d         = '0;
          err_d        = 1'b0;
          state_d      = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      sp_q           <= '0;
      err_q          <= 1'b0;
      op_q           <= '0;
      input_ack_q    <= 1'b0;
      output_stb_q   <= 1'b0;
      output_data_q  <= '0;
      output_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      err_q          <= err_d;
      op_q           <= op_d;
      input_ack_q    <= input_ack_d;
      output_stb_q   <= output_stb_d;
      output_data_q  <= output_data_d;
      output_error_q <= output_error_d;
      if (stack_we) begin
        stack_q[stack_waddr] <= stack_wdata;
      end
    end
  end

  assign input_ack    = input_ack_q;
  assign output_stb   = output_stb_q;
  assign output_data  = output_data_q;
  assign output_error = output_error_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator
//   Directed bench for rpn_evaluator: feeds postfix token sequences through
//   the stb/ack handshake and compares each result, error flag, ack latency
//   and handshake timing against hand-computed values.
module tb_rpn_evaluator;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;

  logic             CLK = 1'b0;
  logic             RST;
  logic             input_stb;
  logic [WIDTH-1:0] input_data;
  logic             is_input_operator;
  logic             input_ack;
  logic             output_stb;
  logic [WIDTH-1:0] output_data;
  logic             output_error;
  logic             output_ack;

  int check_count = 0;
  int pass_count  = 0;
  int ack_count   = 0;
  int ack_base;

  rpn_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .input_stb        (input_stb),
    .input_data       (input_data),
    .is_input_operator(is_input_operator),
    .input_ack        (input_ack),
    .output_stb       (output_stb),
    .output_data      (output_data),
    .output_error     (output_error),
    .output_ack       (output_ack)
  );

  always #5 CLK = ~CLK;

  // Tally of input_ack cycles, used to confirm one ack per token.
  always @(posedge CLK) begin
    if (input_ack) ack_count <= ack_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Presents one non-'=' token, waits (bounded) for its ack, and checks the
  // ack latency and that the ack pulse lasts a single cycle.
  task automatic applyStimulus(input logic is_op, input logic [WIDTH-1:0] data,
                               input int exp_latency, input string tag);
    int lat;
    lat               = 0;
    input_stb         = 1'b1;
    is_input_operator = is_op;
    input_data        = data;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (input_ack) begin
        lat = i;
        break;
      end
    end
    input_stb = 1'b0;
    checkOutput({tag, " ack latency"}, WIDTH'(lat), WIDTH'(exp_latency));
    @(posedge CLK); #1;
    checkOutput({tag, " ack single"}, WIDTH'(input_ack), '0);
  endtask

  task automatic pushOperand(input logic [WIDTH-1:0] v);
    applyStimulus(1'b0, v, 1, $sformatf("push %0h", v));
  endtask

  task automatic applyOp(input logic [2:0] code);
    applyStimulus(1'b1, WIDTH'(code), 2, $sformatf("op %0b", code));
  endtask

  // Sends '=', checks the result, holds output_ack low for 'hold' cycles
  // while checking stability, then takes the result and checks the '=' ack.
  task automatic evalEquals(input logic [WIDTH-1:0] exp_data, input logic exp_err,
                            input int hold, input string tag);
    input_stb         = 1'b1;
    is_input_operator = 1'b1;
    input_data        = WIDTH'(4);
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (output_stb) break;
    end
    checkOutput({tag, " stb"},   WIDTH'(output_stb), WIDTH'(1));
    checkOutput({tag, " data"},  output_data, exp_data);
    checkOutput({tag, " error"}, WIDTH'(output_error), WIDTH'(exp_err));
    checkOutput({tag, " no early ack"}, WIDTH'(input_ack), '0);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      checkOutput({tag, " hold stb"},   WIDTH'(output_stb), WIDTH'(1));
      checkOutput({tag, " hold data"},  output_data, exp_data);
      checkOutput({tag, " hold error"}, WIDTH'(output_error), WIDTH'(exp_err));
      checkOutput({tag, " hold no ack"}, WIDTH'(input_ack), '0);
    end
    output_ack = 1'b1;
    @(posedge CLK); #1;
    output_ack = 1'b0;
    input_stb  = 1'b0;
    checkOutput({tag, " stb cleared"}, WIDTH'(output_stb), '0);
    checkOutput({tag, " eq ack"},      WIDTH'(input_ack), WIDTH'(1));
    @(posedge CLK); #1;
    checkOutput({tag, " eq ack single"}, WIDTH'(input_ack), '0);
  endtask

  initial begin
    RST               = 1'b1;
    input_stb         = 1'b0;
    input_data        = '0;
    is_input_operator = 1'b0;
    output_ack        = 1'b0;
    @(posedge CLK); #1;
    checkOutput("reset input_ack",    WIDTH'(input_ack), '0);
    checkOutput("reset output_stb",   WIDTH'(output_stb), '0);
    checkOutput("reset output_error", WIDTH'(output_error), '0);
    checkOutput("reset output_data",  output_data, '0);
    RST = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] 3 4 + 2 * =");
    ack_base = ack_count;
    pushOperand(3); pushOperand(4); applyOp(3'b010);
    pushOperand(2); applyOp(3'b001);
    evalEquals(14, 1'b0, 0, "expr1");
    checkOutput("expr1 ack count", WIDTH'(ack_count - ack_base), WIDTH'(6));
    checkOutput("expr1 sp after", WIDTH'(dut.sp_q), '0);

    $display("[TB] subtraction order");
    pushOperand(10); pushOperand(3); applyOp(3'b011);
    evalEquals(7, 1'b0, 0, "10-3");
    pushOperand(3); pushOperand(10); applyOp(3'b011);
    evalEquals(32'hFFFF_FFF9, 1'b0, 0, "3-10");

    $display("[TB] wraparound");
    pushOperand(32'h1_0000); pushOperand(32'h1_0000); applyOp(3'b001);
    evalEquals(0, 1'b0, 0, "mul wrap");
    pushOperand(32'h7FFF_FFFF); pushOperand(1); applyOp(3'b010);
    evalEquals(32'h8000_0000, 1'b0, 0, "add wrap");

    $display("[TB] faults");
    pushOperand(5); applyOp(3'b010);
    evalEquals(5, 1'b1, 0, "underflow");
    pushOperand(1); pushOperand(2);
    evalEquals(2, 1'b1, 0, "leftover");
    applyStimulus(1'b1, WIDTH'(3'b111), 1, "illegal op");
    pushOperand(4);
    evalEquals(4, 1'b1, 0, "illegal");
    evalEquals(0, 1'b1, 0, "lone eq");
    pushOperand(6); pushOperand(7); applyOp(3'b001);
    evalEquals(42, 1'b0, 0, "clean after fault");

    $display("[TB] overflow with delayed output_ack");
    for (int i = 1; i <= DEPTH + 1; i++) pushOperand(WIDTH'(i));
    evalEquals(WIDTH'(DEPTH), 1'b1, 5, "overflow");

    $display("[TB] converter output for 2+3*4=");
    pushOperand(2); pushOperand(3); pushOperand(4);
    applyOp(3'b001); applyOp(3'b010);
    evalEquals(14, 1'b0, 0, "chained");

    $display("[TB] reset during RESULT");
    pushOperand(9);
    input_stb         = 1'b1;
    is_input_operator = 1'b1;
    input_data        = WIDTH'(4);
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (output_stb) break;
    end
    checkOutput("pre-reset stb", WIDTH'(output_stb), WIDTH'(1));
    RST       = 1'b1;
    input_stb = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("mid reset stb", WIDTH'(output_stb), '0);
    checkOutput("mid reset ack", WIDTH'(input_ack), '0);
    @(posedge CLK); #1;
    pushOperand(1); pushOperand(1); applyOp(3'b010);
    evalEquals(2, 1'b0, 0, "after reset");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
